// File: rtl/qpsk_demodulator.sv
// QPSK hard-slicing receiver: symbol-aligned preamble search, payload byte assembly and an
// output byte FIFO with valid/ready handshake and sop/eop tags.
module qpsk_demodulator #(
    parameter int unsigned              SIZE_BIT_PACK = 1976,
    parameter int unsigned              SIZE_PREAMBLE = 32,
    parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE      = 32'h1ACF_FC1D,
    parameter int unsigned              MAX_ERR       = 0,
    parameter int unsigned              SIZE_QI       = 16,
    parameter int unsigned              FIFO_DEPTH    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [2*SIZE_QI-1:0]   i_data,
    input  logic                   i_valid_input,
    output logic [7:0]             o_data,
    output logic                   o_valid_output,
    input  logic                   i_ready,
    output logic                   o_sop,
    output logic                   o_eop,
    output logic                   o_lock,
    output logic                   o_pack_done,
    output logic                   o_overflow
);

    localparam int unsigned PAYLOAD_BITS  = SIZE_BIT_PACK - SIZE_PREAMBLE;
    localparam int unsigned PAYLOAD_BYTES = PAYLOAD_BITS / 8;
    localparam int unsigned CNT_W         = $clog2(PAYLOAD_BITS + 1);
    localparam int unsigned IDX_W         = CNT_W - 3;
    localparam int unsigned ERR_W         = $clog2(SIZE_PREAMBLE + 1);
    localparam int unsigned PTR_W         = $clog2(FIFO_DEPTH);

    typedef enum logic {
        S_SEARCH,
        S_PAYLOAD
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [SIZE_PREAMBLE-1:0] r_sr;
    logic [SIZE_PREAMBLE-1:0] w_sr_next;
    logic [SIZE_PREAMBLE-1:0] w_diff;
    logic [ERR_W-1:0]         w_err_cnt;
    logic                     w_match;
    logic                     w_bit_i;
    logic                     w_bit_q;
    logic                     w_unused_bits;
    logic [CNT_W-1:0]         r_bit_cnt;
    logic [7:0]               r_byte;
    logic [7:0]               w_byte_next;
    logic [IDX_W-1:0]         w_byte_idx;
    logic                     w_byte_done;
    logic                     w_sop;
    logic                     w_eop;
    logic                     w_last;
    logic                     r_pack_done;
    logic                     r_overflow;

    logic [9:0]               r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W:0]           r_count;
    logic                     w_pop;
    logic                     w_push_ok;
    logic                     w_not_empty;
    logic [9:0]               w_head;

    // Hard slice: the sign bit is the decision (negative -> 1, zero/positive -> 0).
    assign w_bit_i       = i_data[2*SIZE_QI-1];
    assign w_bit_q       = i_data[SIZE_QI-1];
    assign w_unused_bits = ^{i_data[2*SIZE_QI-2:SIZE_QI], i_data[SIZE_QI-2:0]};

    assign w_sr_next = {r_sr[SIZE_PREAMBLE-3:0], w_bit_i, w_bit_q};
    assign w_diff    = w_sr_next ^ PREAMBLE;

    always_comb begin
        w_err_cnt = '0;
        for (int k = 0; k < SIZE_PREAMBLE; k++) begin
            w_err_cnt = w_err_cnt + ERR_W'(w_diff[k]);
        end
    end

    assign w_match = (w_err_cnt <= ERR_W'(MAX_ERR));

    // Four samples per byte: the byte closes when the two bits already held are 6 mod 8.
    assign w_byte_next = {r_byte[5:0], w_bit_i, w_bit_q};
    assign w_byte_idx  = r_bit_cnt[CNT_W-1:3];
    assign w_byte_done = (r_state == S_PAYLOAD) && i_valid_input && (r_bit_cnt[2:1] == 2'b11);
    assign w_sop       = (w_byte_idx == IDX_W'(0));
    assign w_eop       = (w_byte_idx == IDX_W'(PAYLOAD_BYTES - 1));
    assign w_last      = w_byte_done && w_eop;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SEARCH:  if (i_valid_input && w_match) w_state_next = S_PAYLOAD;
            S_PAYLOAD: if (w_last) w_state_next = S_SEARCH;
            default:   w_state_next = S_SEARCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_SEARCH;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_byte      <= '0;
            r_pack_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pack_done <= w_last;
            if (r_state == S_SEARCH) begin
                if (i_valid_input) begin
                    r_sr <= w_sr_next;
                    if (w_match) begin
                        r_bit_cnt <= '0;
                        r_byte    <= '0;
                    end
                end
            end else if (i_valid_input) begin
                r_byte    <= w_byte_next;
                r_bit_cnt <= r_bit_cnt + CNT_W'(2);
                // Clearing sr forces the next packet to present its full preamble.
                if (w_last) begin
                    r_sr <= '0;
                end
            end
        end
    end

    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty && i_ready;
    assign w_push_ok   = w_byte_done && ((r_count < (PTR_W+1)'(FIFO_DEPTH)) || w_pop);
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_sop, w_eop, w_byte_next};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_byte_done && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head fields are masked while empty so stale storage never reaches the outputs.
    assign o_data         = w_not_empty ? w_head[7:0] : 8'h00;
    assign o_sop          = w_not_empty && w_head[9];
    assign o_eop          = w_not_empty && w_head[8];
    assign o_valid_output = w_not_empty;
    assign o_lock         = (r_state == S_PAYLOAD);
    assign o_pack_done    = r_pack_done;
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Self-checking bench for qpsk_demodulator: randomized sample amplitudes, gaps and ready,
// checked against a bit-stream reference model of preamble search and byte framing.
module tb_qpsk_demodulator;

    localparam logic [31:0] PRE       = 32'h1ACF_FC1D;
    localparam int          MAX_ERR   = 2;
    localparam int          PAY_BYTES = 243;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        vin;
    logic        rdy;
    logic [7:0]  dout;
    logic        vout, sop, eop, lock, pdone, ovf;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  got_q[$];
    logic [9:0]  exp_q[$];
    bit          sent_bits[$];
    int          done_cnt;
    int          exp_done;
    int          lock_at_done;
    bit          lock_seen;
    bit          gap_mode;
    bit          rand_rdy;

    qpsk_demodulator #(
        .SIZE_BIT_PACK(1976),
        .SIZE_PREAMBLE(32),
        .PREAMBLE     (PRE),
        .MAX_ERR      (MAX_ERR),
        .SIZE_QI      (16),
        .FIFO_DEPTH   (16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_data        (din),
        .i_valid_input (vin),
        .o_data        (dout),
        .o_valid_output(vout),
        .i_ready       (rdy),
        .o_sop         (sop),
        .o_eop         (eop),
        .o_lock        (lock),
        .o_pack_done   (pdone),
        .o_overflow    (ovf)
    );

    always #5 clk = ~clk;

    // Record what the consumer accepts; a pop happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (vout && rdy) got_q.push_back({sop, eop, dout});
            if (pdone) begin
                done_cnt++;
                if (lock) lock_at_done++;
            end
            if (lock) lock_seen = 1'b1;
        end
    end

    function automatic void clear_obs();
        got_q.delete();
        sent_bits.delete();
        done_cnt     = 0;
        lock_at_done = 0;
        lock_seen    = 1'b0;
    endfunction

    // Reference: sliding Hamming search over the sent bit stream, then fixed-length framing.
    function automatic void run_model();
        logic [31:0] win    = '0;
        logic [7:0]  acc    = '0;
        bit          locked = 1'b0;
        int          nbits  = 0;
        int          idx;
        exp_q.delete();
        exp_done = 0;
        for (int i = 0; i + 1 < sent_bits.size(); i += 2) begin
            if (!locked) begin
                win = {win[29:0], sent_bits[i], sent_bits[i+1]};
                if ($countones(win ^ PRE) <= MAX_ERR) begin
                    locked = 1'b1;
                    nbits  = 0;
                end
            end else begin
                acc   = {acc[5:0], sent_bits[i], sent_bits[i+1]};
                nbits = nbits + 2;
                if (nbits % 8 == 0) begin
                    idx = nbits / 8 - 1;
                    exp_q.push_back({idx == 0, idx == PAY_BYTES - 1, acc});
                    if (idx == PAY_BYTES - 1) begin
                        locked = 1'b0;
                        win    = '0;
                        exp_done++;
                    end
                end
            end
        end
    endfunction

    task automatic send_raw(input logic [31:0] s, input bit bi, input bit bq);
        while (gap_mode && $urandom_range(0, 1) == 1) begin
            vin = 1'b0;
            if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        din = s;
        vin = 1'b1;
        if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
        sent_bits.push_back(bi);
        sent_bits.push_back(bq);
        @(posedge clk); #1;
        vin = 1'b0;
    endtask

    task automatic send_sym(input bit bi, input bit bq, input int amp);
        int vi, vq;
        if (amp > 0) begin
            vi = bi ? -amp : amp;
            vq = bq ? -amp : amp;
        end else begin
            vi = bi ? -int'($urandom_range(1, 32768)) : int'($urandom_range(0, 32767));
            vq = bq ? -int'($urandom_range(1, 32768)) : int'($urandom_range(0, 32767));
        end
        send_raw({vi[15:0], vq[15:0]}, bi, bq);
    endtask

    task automatic send_preamble(input logic [31:0] flips, input int amp);
        logic [31:0] p;
        p = PRE ^ flips;
        for (int k = 0; k < 16; k++) send_sym(p[31-2*k], p[30-2*k], amp);
    endtask

    task automatic send_payload(input logic [7:0] pay[$], input int amp);
        logic [7:0] b;
        foreach (pay[n]) begin
            b = pay[n];
            for (int k = 3; k >= 0; k--) send_sym(b[2*k+1], b[2*k], amp);
        end
    endtask

    task automatic drain(output bit ok);
        rdy = 1'b1;
        ok  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!vout) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        vin = 1'b0;
        @(posedge clk); #1;
        clear_obs();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b0; rdy = 1'b1; din = '0;
        gap_mode = 1'b0; rand_rdy = 1'b0;
        clear_obs();
        #2;
        checks++;
        if ({dout, vout, sop, eop, lock, pdone, ovf} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {dout, vout, sop, eop, lock, pdone, ovf});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dout, vout, sop, eop, lock, pdone, ovf} !== 14'h0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h required 0", {dout, vout, sop, eop, lock, pdone, ovf});
        end
    endtask

    task automatic test_clean();
        logic [7:0] pay[$];
        bit         ok;
        logic [7:0] bv;
        apply_reset();
        for (int i = 0; i < PAY_BYTES; i++) pay.push_back(i[7:0]);
        send_preamble(32'h0, 8192);
        @(negedge clk);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("FAIL lock_after_preamble: got %b required 1", lock);
        end
        @(posedge clk); #1;
        send_payload(pay, 8192);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != PAY_BYTES) begin
            errors++;
            $display("FAIL clean_count: got %0d bytes required %0d", got_q.size(), PAY_BYTES);
        end
        for (int i = 0; i < PAY_BYTES && i < got_q.size(); i++) begin
            bv = i[7:0];
            checks++;
            if (got_q[i] !== {i == 0, i == PAY_BYTES - 1, bv}) begin
                errors++;
                $display("FAIL clean_byte[%0d]: got %h required %h", i, got_q[i],
                         {i == 0, i == PAY_BYTES - 1, bv});
            end
        end
        checks++;
        if (done_cnt != 1 || lock_at_done != 0 || ovf !== 1'b0 || lock !== 1'b0) begin
            errors++;
            $display("FAIL clean_done: got done=%0d lock_at_done=%0d ovf=%b lock=%b required 1 0 0 0",
                     done_cnt, lock_at_done, ovf, lock);
        end
    endtask

    task automatic test_preamble_errors();
        logic [7:0] pay[$];
        bit         ok;
        apply_reset();
        for (int i = 0; i < PAY_BYTES; i++) pay.push_back(8'($urandom));
        send_preamble(32'h0010_0400, 0);
        send_payload(pay, 0);
        drain(ok);
        run_model();
        checks++;
        if (!ok || got_q.size() != PAY_BYTES || exp_q.size() != PAY_BYTES) begin
            errors++;
            $display("FAIL flip2_count: got %0d bytes required %0d", got_q.size(), PAY_BYTES);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_q[i][7:0] !== pay[i]) begin
                errors++;
                $display("FAIL flip2_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        apply_reset();
        send_preamble(32'h8010_0400, 0);
        send_payload(pay, 0);
        drain(ok);
        checks++;
        if (got_q.size() != 0 || lock_seen || done_cnt != 0) begin
            errors++;
            $display("FAIL flip3_nolock: got %0d bytes lock_seen=%b done=%0d required 0 0 0",
                     got_q.size(), lock_seen, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pay[$];
        bit         ok;
        logic [7:0] bv;
        apply_reset();
        for (int i = 0; i < PAY_BYTES; i++) pay.push_back(i[7:0]);
        rdy = 1'b0;
        send_preamble(32'h0, 0);
        send_payload(pay, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vout !== 1'b1 || ovf !== 1'b1 || got_q.size() != 0 || {sop, dout} !== 9'h100) begin
            errors++;
            $display("FAIL bp_hold: got vout=%b ovf=%b popped=%0d head=%b_%h required 1 1 0 1_00",
                     vout, ovf, got_q.size(), sop, dout);
        end
        @(posedge clk); #1;
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 16 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: got %0d bytes ovf=%b required 16 1", got_q.size(), ovf);
        end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            bv = i[7:0];
            checks++;
            if (got_q[i] !== {i == 0, 1'b0, bv}) begin
                errors++;
                $display("FAIL bp_byte[%0d]: got %h required %h", i, got_q[i], {i == 0, 1'b0, bv});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pay[$];
        logic [7:0] part[$];
        bit         ok;
        apply_reset();
        for (int i = 0; i < PAY_BYTES; i++) pay.push_back(8'($urandom));
        for (int i = 0; i < 101; i++) part.push_back(pay[i]);
        rdy = 1'b0;
        send_preamble(32'h0, 0);
        send_payload(part, 0);
        checks++;
        if (vout !== 1'b1 || lock !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: got vout=%b lock=%b required 1 1", vout, lock);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({dout, vout, sop, eop, lock, pdone, ovf} !== 14'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h required 0", {dout, vout, sop, eop, lock, pdone, ovf});
        end
        clear_obs();
        @(posedge clk); #1;
        rst = 1'b0;
        rdy = 1'b1;
        @(posedge clk); #1;
        send_preamble(32'h0, 0);
        send_payload(pay, 0);
        drain(ok);
        run_model();
        checks++;
        if (!ok || got_q.size() != PAY_BYTES || exp_q.size() != PAY_BYTES || done_cnt != 1) begin
            errors++;
            $display("FAIL mid_after_count: got %0d bytes done=%0d required %0d 1",
                     got_q.size(), done_cnt, PAY_BYTES);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_after_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa[$];
        logic [7:0] pb[$];
        bit         ok;
        apply_reset();
        for (int i = 0; i < PAY_BYTES; i++) begin
            pa.push_back(8'($urandom));
            pb.push_back(8'($urandom));
        end
        gap_mode = 1'b1;
        rand_rdy = 1'b1;
        send_preamble(32'h0, 0);
        send_payload(pa, 0);
        send_preamble(32'h0, 0);
        send_payload(pb, 0);
        gap_mode = 1'b0;
        rand_rdy = 1'b0;
        drain(ok);
        run_model();
        checks++;
        if (!ok || got_q.size() != 2 * PAY_BYTES || exp_q.size() != 2 * PAY_BYTES) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes required %0d", got_q.size(), 2 * PAY_BYTES);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != exp_done || done_cnt != 2 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: got done=%0d ovf=%b required 2 0", done_cnt, ovf);
        end
    endtask

    task automatic test_zero_samples();
        bit ok;
        apply_reset();
        rdy = 1'b1;
        send_preamble(32'h0, 0);
        for (int k = 0; k < 4; k++) send_raw(32'h0000_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({vout, sop, eop, dout} !== 11'b110_0101_0101) begin
            errors++;
            $display("FAIL zero_first_byte: got %b required 11001010101", {vout, sop, eop, dout});
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4 * (PAY_BYTES - 1); k++) send_raw(32'h0000_FFFF, 1'b0, 1'b1);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != PAY_BYTES || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_count: got %0d bytes done=%0d required %0d 1",
                     got_q.size(), done_cnt, PAY_BYTES);
        end
        for (int i = 0; i < PAY_BYTES && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {i == 0, i == PAY_BYTES - 1, 8'h55}) begin
                errors++;
                $display("FAIL zero_byte[%0d]: got %h required %h", i, got_q[i],
                         {i == 0, i == PAY_BYTES - 1, 8'h55});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_preamble_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_zero_samples();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpsk_demodulator.md
# qpsk_demodulator

Receive-side counterpart of the QPSK `Modulator`. It takes a stream of 32-bit I/Q samples (one per symbol), hard-slices each sample to 2 bits and searches for the 32-bit preamble. After the preamble it de-serialises the fixed-length payload into bytes and delivers them through a small FIFO with a valid/ready handshake. It sits between the channel/sample source and the byte-oriented packet consumer.

## Interface
- SIZE_BIT_PACK, 1976: total packet bits, preamble included.
- SIZE_PREAMBLE, 32: preamble length in bits.
- PREAMBLE, 32'hXXXX_XXXX (project constant): expected preamble; bit [31] is transmitted first.
- MAX_ERR, 0: maximum Hamming mismatches accepted for preamble lock.
- SIZE_QI, 16: width of each of I and Q.
- FIFO_DEPTH, 16: output byte FIFO depth, power of 2.
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_data  in  32  sample: I = [31:16], Q = [15:0], both signed.
- i_valid_input  in  1  sample valid. There is no upstream backpressure, so every valid sample is consumed.
- o_data  out  8  payload byte at the FIFO head.
- o_valid_output  out  1  FIFO not empty.
- i_ready  in  1  consumer accepts; a pop happens when o_valid_output && i_ready.
- o_sop  out  1  head byte is the first payload byte of a packet.
- o_eop  out  1  head byte is the last payload byte of a packet.
- o_lock  out  1  high while in PAYLOAD state.
- o_pack_done  out  1  one-cycle pulse when the last payload byte is written.
- o_overflow  out  1  sticky flag; a completed byte was dropped because the FIFO was full.

## Operation
- Slicing: each valid sample gives bit_I = I[SIZE_QI-1] and bit_Q = Q[SIZE_QI-1]. Negative slices to 1; zero and positive slice to 0. Order on the wire is bit_I first, then bit_Q.
- PAYLOAD_BITS = SIZE_BIT_PACK − SIZE_PREAMBLE = 1944 bits = 243 bytes. PAYLOAD_BITS must be a multiple of 8, and SIZE_PREAMBLE must be even.
- The preamble is symbol-aligned. There is no bit-phase search.
- State SEARCH:
  - On each valid sample, sr ← {sr[29:0], bit_I, bit_Q}.
  - If popcount(next_sr ^ PREAMBLE) ≤ MAX_ERR, go to PAYLOAD at that edge.
  - Bit counter and byte assembler are cleared on entry to PAYLOAD.
- State PAYLOAD:
  - On each valid sample, shift both bits into the byte assembler, MSB first.
  - bit_cnt += 2.
  - Every 4th sample completes a byte, which is pushed together with its sop/eop tags.
  - sop is set on byte 0; eop is set on byte 242.
  - When the eop byte is pushed: o_pack_done pulses, state returns to SEARCH, and sr is cleared to 0. The next packet therefore needs its full preamble.
- FIFO: holds {sop, eop, byte}, registered storage, head read combinationally.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and o_overflow ← 1. The packet continues, and bit counting is unaffected.
- The preamble is never forwarded. Samples outside a packet are only used for search.

## Timing
- Reset values: all outputs 0, state SEARCH, sr = 0, FIFO empty, o_overflow cleared.
- Reset is asynchronous. Asserting it mid-packet aborts the packet immediately and flushes the FIFO contents.
- Lock: the sample completing the preamble is registered at edge N. o_lock is high from N+1, and the next valid sample is payload bit 0/1.
- Byte latency: the 4th sample of a byte is registered at edge N. The byte is at the head, with o_valid_output = 1 if the FIFO was empty, from N+1.
- Pop: o_data/o_sop/o_eop update in the cycle after the accepting edge.
- Gaps in i_valid_input only stall the counters; no state is lost.
- o_pack_done is high for the single cycle following the edge that pushed the eop byte. o_lock falls in the same cycle.
- Maximum throughput: 1 sample/cycle, which is 1 byte per 4 cycles. The consumer with i_ready = 1 never overflows.

## Test plan
- Clean packet: 16 preamble symbols mapped ±8192, then payload bytes 0x00..0xF2 modulated; i_ready = 1 → exactly 243 bytes 0x00..0xF2 out, o_sop with 0x00, o_eop with 0xF2, one o_pack_done pulse, o_overflow = 0.
- Preamble errors, MAX_ERR = 2:
  - 2 flipped preamble bits → lock and correct payload.
  - 3 flipped bits → no lock, no bytes output.
- Backpressure: i_ready = 0 for the whole packet, FIFO_DEPTH = 16 → o_valid_output = 1 with bytes 0x00..0x0F retained, o_overflow = 1. Then raise i_ready → exactly 16 bytes pop in order.
- Reset mid-payload: assert i_reset after byte 100 → outputs 0 and FIFO empty immediately. A following complete packet decodes correctly.
- Random valid gaps (50% duty) plus two back-to-back packets with different payloads → 486 bytes, correct sop/eop per packet, two o_pack_done pulses.
- Zero samples: payload symbols with I = 0, Q = −1 → decoded bits 0,1 per symbol, giving byte 0x55.
